// File: rtl/status_led_ctrl.sv
// rtl/status_led_ctrl.sv - button debounce, heartbeat, activity stretch and LED mode mux
// Optional PWM dimming of the lit LEDs: define STATUS_LED_PWM_EN.
module status_led_ctrl #(
  parameter int NUM_BTN        = 2,
  parameter int NUM_LED        = 1,
  parameter int DEB_CYC        = 1_000_000,
  parameter int HB_HALF        = 50_000_000,
  parameter int STRETCH_CYC    = 2_500_000,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic               clk50,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_LED-1:0] act_in,
  output logic [NUM_LED-1:0] led_out,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [1:0]         mode
`ifdef STATUS_LED_PWM_EN
  ,
  input  logic [7:0]         pwm_duty
`endif
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int HB_W  = $clog2(HB_HALF + 1);
  localparam int ST_W  = $clog2(STRETCH_CYC);

  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [HB_W-1:0]    HB_LAST  = HB_W'(HB_HALF - 1);
  localparam logic [ST_W-1:0]    ST_LOAD  = ST_W'(STRETCH_CYC - 1);
  localparam logic [NUM_BTN-1:0] BTN_IDLE = {NUM_BTN{BTN_ACTIVE_LOW}};
  localparam logic [NUM_LED-1:0] LED_OFF  = {NUM_LED{LED_ACTIVE_LOW}};

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] pressed;
  logic [NUM_BTN-1:0] level_prev;
  logic [HB_W-1:0]    hb_cnt;
  logic               hb;
  logic               hold;
  logic [NUM_LED-1:0] act;
  logic [NUM_LED-1:0] lit;

  // Synchronisers reset to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= BTN_IDLE;
      sync2 <= BTN_IDLE;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign pressed = BTN_ACTIVE_LOW ? ~sync2 : sync2;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    logic [DEB_W-1:0] deb_cnt;
    logic             level;

    always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt <= '0;
        level   <= 1'b0;
      end else if (pressed[b] == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        level   <= ~level;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end

    assign btn_level[b] = level;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= '0;
      btn_press  <= '0;
    end else begin
      level_prev <= btn_level;
      btn_press  <= btn_level & ~level_prev;
    end
  end

  assign hold = btn_level[1];

  // Hold is checked before the wrap so it wins on the wrap cycle.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hold) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + HB_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_led
    logic [ST_W-1:0] st_cnt;

    always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
        st_cnt <= '0;
      end else if (act_in[i]) begin
        st_cnt <= ST_LOAD;
      end else if (st_cnt != '0) begin
        st_cnt <= st_cnt - ST_W'(1);
      end
    end

    assign act[i] = act_in[i] | (st_cnt != '0);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      mode <= 2'd0;
    end else if (btn_press[0]) begin
      mode <= mode + 2'd1;
    end
  end

`ifdef STATUS_LED_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    lit = '0;
    case (mode)
      2'd0:    lit = {NUM_LED{hb}};
      2'd1:    lit = act | {NUM_LED{hb}};
      2'd2:    lit = act;
      default: lit = '0;
    endcase
`ifdef STATUS_LED_PWM_EN
    if (!(pwm_cnt < pwm_duty)) begin
      lit = '0;
    end
`endif
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= LED_OFF;
    end else begin
      led_out <= LED_ACTIVE_LOW ? ~lit : lit;
    end
  end

endmodule
